// File: rtl/bht_resolve_update_pkg.sv
// Shared types and counter helper for the branch history table.
// The type set stays fixed whether or not BHT_UPDATE_BYPASS_EN is defined.
package bht_resolve_update_pkg;

    localparam int VLEN = 64;

    typedef enum logic [2:0] {
        NoCF   = 3'd0,
        Branch = 3'd1,
        Jump   = 3'd2,
        JumpR  = 3'd3,
        Return = 3'd4
    } cf_t;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target_address;
        logic            is_mispredict;
        logic            is_taken;
        cf_t             cf_type;
    } bp_resolve_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] ctr;
    } bht_entry_t;

    // Saturating 2-bit counter step; never wraps.
    function automatic logic [1:0] bht_ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end
        return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/bht_update_pipe.sv
// Accept logic and one-deep update pipeline register for the BHT.
// BHT_UPDATE_BYPASS_EN adds a pending-index compare against the lookup index.
module bht_update_pipe
    import bht_resolve_update_pkg::*;
#(
    parameter int IDX_W     = 10,
    parameter int PC_OFFSET = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_debug_mode,
    input  bp_resolve_t      i_resolved,
    input  logic [IDX_W-1:0] i_lookup_idx,
    output logic             o_pend_valid,
    output logic [IDX_W-1:0] o_pend_idx,
    output logic             o_pend_taken,
    output logic             o_bypass_hit
);

    logic             r_pend_valid;
    logic [IDX_W-1:0] r_pend_idx;
    logic             r_pend_taken;
    logic             w_accept;
    logic             w_unused_res;

    assign w_accept = i_resolved.valid && (i_resolved.cf_type == Branch)
                      && !i_debug_mode && !i_flush;

    assign w_unused_res = ^{i_resolved.pc, i_resolved.target_address, i_resolved.is_mispredict};

    // A flush cycle never accepts, so it also empties the register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_idx   <= '0;
            r_pend_taken <= 1'b0;
        end else begin
            r_pend_valid <= w_accept;
            if (w_accept) begin
                r_pend_idx   <= i_resolved.pc[PC_OFFSET +: IDX_W];
                r_pend_taken <= i_resolved.is_taken;
            end
        end
    end

`ifdef BHT_UPDATE_BYPASS_EN
    assign o_bypass_hit = r_pend_valid && (r_pend_idx == i_lookup_idx) && !i_flush;
`else
    logic w_unused_idx;
    assign w_unused_idx = ^i_lookup_idx;
    assign o_bypass_hit = 1'b0;
`endif

    assign o_pend_valid = r_pend_valid;
    assign o_pend_idx   = r_pend_idx;
    assign o_pend_taken = r_pend_taken;

endmodule

// File: rtl/bht_resolve_update.sv
// Branch history table: 2-bit counters trained from resolved branches, 0-latency lookup.
// Optional BHT_UPDATE_BYPASS_EN forwards the in-flight write to a matching lookup.
module bht_resolve_update
    import bht_resolve_update_pkg::*;
#(
    parameter int NR_ENTRIES = 1024,
    parameter int PC_OFFSET  = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            debug_mode_i,
    input  logic [VLEN-1:0] vpc_i,
    input  bp_resolve_t     resolved_branch_i,
    output bht_prediction_t bht_prediction_o,
    output logic            update_pending_o
);

    localparam int IDX_W = $clog2(NR_ENTRIES);

    bht_entry_t       r_table [NR_ENTRIES];
    logic [IDX_W-1:0] w_lookup_idx;
    logic [IDX_W-1:0] w_pend_idx;
    logic             w_pend_valid;
    logic             w_pend_taken;
    logic             w_bypass_hit;
    bht_entry_t       w_rd_entry;
    bht_entry_t       w_wr_old;
    bht_entry_t       w_wr_entry;
    logic             w_unused_vpc;

    assign w_lookup_idx = vpc_i[PC_OFFSET +: IDX_W];
    assign w_unused_vpc = ^vpc_i;

    bht_update_pipe #(
        .IDX_W    (IDX_W),
        .PC_OFFSET(PC_OFFSET)
    ) u_pipe (
        .i_clk       (clk_i),
        .i_rst_n     (rst_ni),
        .i_flush     (flush_i),
        .i_debug_mode(debug_mode_i),
        .i_resolved  (resolved_branch_i),
        .i_lookup_idx(w_lookup_idx),
        .o_pend_valid(w_pend_valid),
        .o_pend_idx  (w_pend_idx),
        .o_pend_taken(w_pend_taken),
        .o_bypass_hit(w_bypass_hit)
    );

    assign w_rd_entry = r_table[w_lookup_idx];
    assign w_wr_old   = r_table[w_pend_idx];

    // A first touch seeds the weak state in the resolved direction.
    always_comb begin
        w_wr_entry.valid = 1'b1;
        if (w_wr_old.valid) begin
            w_wr_entry.ctr = bht_ctr_next(w_wr_old.ctr, w_pend_taken);
        end else begin
            w_wr_entry.ctr = w_pend_taken ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        bht_prediction_o.valid = w_rd_entry.valid;
        bht_prediction_o.taken = w_rd_entry.valid & w_rd_entry.ctr[1];
        if (w_bypass_hit) begin
            bht_prediction_o.valid = 1'b1;
            bht_prediction_o.taken = w_wr_entry.ctr[1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            foreach (r_table[i]) r_table[i] <= '0;
        end else if (flush_i) begin
            foreach (r_table[i]) r_table[i].valid <= 1'b0;
        end else if (w_pend_valid) begin
            r_table[w_pend_idx] <= w_wr_entry;
        end
    end

    assign update_pending_o = w_pend_valid;

endmodule
